// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD engine host-side sequencer.
package gcd_pkg;

    localparam int GCD_WIDTH   = 16;
    localparam int GCD_TIMEOUT = 1024;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT_DONE,
        S_RESP
    } gcd_state_e;

endpackage

// File: rtl/gcd_operand_sequencer_if.sv
// Request, engine and response signals of the GCD operand sequencer.
interface gcd_operand_sequencer_if
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH
) ();

    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             gcd_start;
    logic [WIDTH-1:0] gcd_data;
    logic             gcd_done;
    logic [WIDTH-1:0] gcd_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_err;

    // master = the sequencer itself
    modport master (
        input  req_valid, req_a, req_b,
        input  gcd_done, gcd_result,
        input  rsp_ready,
        output req_ready,
        output gcd_start, gcd_data,
        output rsp_valid, rsp_result, rsp_err
    );

    modport slave (
        output req_valid, req_a, req_b,
        output gcd_done, gcd_result,
        output rsp_ready,
        input  req_ready,
        input  gcd_start, gcd_data,
        input  rsp_valid, rsp_result, rsp_err
    );

endinterface

// File: rtl/gcd_timeout_counter.sv
// Saturating cycle counter that flags expiry at TIMEOUT-1.
module gcd_timeout_counter
    import gcd_pkg::*;
#(
    parameter  int TIMEOUT = GCD_TIMEOUT,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/gcd_operand_sequencer.sv
// Host-side initiator: accepts an operand pair, drives the GCD engine,
// and returns its result (or an error on zero operands / engine hang).
module gcd_operand_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input logic                     clk,
    input logic                     rst_n,
    gcd_operand_sequencer_if.master bus
);

    gcd_state_e       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] result_q;
    logic             req_ready_q;
    logic             start_q;
    logic             rsp_valid_q;
    logic             err_q;
    logic             expired;

    gcd_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .clear_i  (state_q == S_LOAD_B),
        .enable_i (state_q == S_WAIT_DONE),
        .expired_o(expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            data_q      <= '0;
            result_q    <= '0;
            req_ready_q <= 1'b1;
            start_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        a_q         <= bus.req_a;
                        b_q         <= bus.req_b;
                        req_ready_q <= 1'b0;
                        // A zero operand never reaches the engine; OR yields the other one
                        if (bus.req_a == '0 || bus.req_b == '0) begin
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            result_q    <= bus.req_a | bus.req_b;
                            err_q       <= (bus.req_a == '0) && (bus.req_b == '0);
                        end else begin
                            state_q <= S_START;
                            start_q <= 1'b1;
                            data_q  <= '0;
                        end
                    end
                end
                S_START: begin
                    state_q <= S_LOAD_A;
                    data_q  <= a_q;
                end
                S_LOAD_A: begin
                    state_q <= S_LOAD_B;
                    start_q <= 1'b0;
                    data_q  <= b_q;
                end
                S_LOAD_B: begin
                    state_q <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (bus.gcd_done) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        result_q    <= bus.gcd_result;
                        err_q       <= 1'b0;
                    end else if (expired) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        result_q    <= '0;
                        err_q       <= 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.gcd_start  = start_q;
    assign bus.gcd_data   = data_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Directed bench for gcd_operand_sequencer with a behavioural GCD engine.
module tb_gcd_operand_sequencer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    gcd_operand_sequencer_if #(.WIDTH(16)) bus ();

    gcd_operand_sequencer #(
        .WIDTH  (16),
        .TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        err;
        int          lat;
        int          starts;
    } vec_t;

    // engine model: start/0, start/A, B, then done after a fixed delay
    int          ph;
    int          cnt;
    int          n_start;
    bit          hang;
    logic [15:0] cap0, cap_a, cap_b;
    logic        st_a, st_b;

    function automatic logic [15:0] gcd_f(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] p = x;
        logic [15:0] q = y;
        logic [15:0] t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    initial n_start = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            ph = 0;
            bus.gcd_done = 1'b0;
            bus.gcd_result = '0;
        end else begin
            if (bus.gcd_start) n_start++;
            case (ph)
                0: if (bus.gcd_start) begin cap0 = bus.gcd_data; ph = 1; end
                1: begin cap_a = bus.gcd_data; st_a = bus.gcd_start; ph = 2; end
                2: begin
                    cap_b = bus.gcd_data;
                    st_b = bus.gcd_start;
                    cnt = 3;
                    ph = hang ? 5 : 3;
                end
                3: if (cnt == 0) begin
                    bus.gcd_done = 1'b1;
                    bus.gcd_result = gcd_f(cap_a, cap_b);
                    ph = 4;
                end else cnt--;
                4: begin bus.gcd_done = 1'b0; ph = 0; end
                5: if (bus.rsp_valid) ph = 0;
                default: ph = 0;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!bus.rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid_seen", bus.rsp_valid, 1);
    endtask

    task automatic run_vec(input string nm, input vec_t v);
        int lat;
        int s0;
        s0 = n_start;
        chk({nm, "_req_ready"}, bus.req_ready, 1);
        bus.req_a = v.a;
        bus.req_b = v.b;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp(lat);
        chk({nm, "_lat"}, lat, v.lat);
        chk({nm, "_result"}, bus.rsp_result, v.res);
        chk({nm, "_err"}, bus.rsp_err, v.err);
        chk({nm, "_busy"}, bus.req_ready, 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk({nm, "_rsp_drop"}, bus.rsp_valid, 0);
        chk({nm, "_ready_back"}, bus.req_ready, 1);
        chk({nm, "_starts"}, n_start - s0, v.starts);
    endtask

    vec_t tbl[8];

    initial begin
        int lat;
        int s0;
        total = 0;
        bad = 0;
        hang = 1'b0;
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b0;

        tbl[0] = '{16'd143,   16'd78,    16'd13,    1'b0, 8, 2};
        tbl[1] = '{16'd0,     16'd25,    16'd25,    1'b0, 1, 0};
        tbl[2] = '{16'd0,     16'd0,     16'd0,     1'b1, 1, 0};
        tbl[3] = '{16'd25,    16'd0,     16'd25,    1'b0, 1, 0};
        tbl[4] = '{16'd21,    16'd14,    16'd7,     1'b0, 8, 2};
        tbl[5] = '{16'd1,     16'd65535, 16'd1,     1'b0, 8, 2};
        tbl[6] = '{16'd65535, 16'd65535, 16'd65535, 1'b0, 8, 2};
        tbl[7] = '{16'd48,    16'd18,    16'd6,     1'b0, 8, 2};

        #12;
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_start", bus.gcd_start, 0);
        chk("rst_data", bus.gcd_data, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_result", bus.rsp_result, 0);
        chk("rst_err", bus.rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // operand serialisation onto the shared bus
        run_vec("seq143", tbl[0]);
        chk("seq_d0", cap0, 0);
        chk("seq_a", cap_a, 143);
        chk("seq_b", cap_b, 78);
        chk("seq_start_a", st_a, 1);
        chk("seq_start_b", st_b, 0);

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // hung engine: WAIT_DONE entered 3 cycles after handshake, 16 more to abort
        hang = 1'b1;
        run_vec("timeout", '{16'd100, 16'd75, 16'd0, 1'b1, 20, 2});
        hang = 1'b0;

        // response backpressure with a competing request
        s0 = n_start;
        bus.req_a = 16'd48;
        bus.req_b = 16'd18;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_rsp(lat);
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = 1'b1;
            bus.req_a = 16'd99;
            bus.req_b = 16'd33;
            @(negedge clk);
            chk("hold_valid", bus.rsp_valid, 1);
            chk("hold_result", bus.rsp_result, 6);
            chk("hold_req_ready", bus.req_ready, 0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("hold_release", bus.rsp_valid, 0);
        chk("hold_starts", n_start - s0, 2);

        // asynchronous reset while waiting on the engine
        bus.req_a = 16'd100;
        bus.req_b = 16'd75;
        bus.req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_data", bus.gcd_data, 75);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_ready", bus.req_ready, 1);
        chk("arst_start", bus.gcd_start, 0);
        chk("arst_data", bus.gcd_data, 0);
        chk("arst_rsp_valid", bus.rsp_valid, 0);
        chk("arst_result", bus.rsp_result, 0);
        chk("arst_err", bus.rsp_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_no_rsp", bus.rsp_valid, 0);
        run_vec("post_rst", '{16'd21, 16'd14, 16'd7, 1'b0, 8, 2});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
